// File: rtl/prog_mem_if.sv
// Load/read bus of the program memory: byte-stream loader inputs, session status and CPU read port.
interface prog_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_in;
  logic              load_done;
  logic              loading;
  logic [ADDR_W:0]   words_loaded;
  logic              overflow;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic [31:0]       checksum;

  modport master (
    output load_start, byte_valid, byte_in, load_done, rd_en, rd_addr,
    input  loading, words_loaded, overflow, rd_data, rd_valid, checksum
  );

  modport slave (
    input  load_start, byte_valid, byte_in, load_done, rd_en, rd_addr,
    output loading, words_loaded, overflow, rd_data, rd_valid, checksum
  );
endinterface

// File: rtl/prog_mem.sv
// Program memory filled from a little-endian byte stream, with a registered CPU read port.
// Optional running checksum of written words is enabled by defining PROG_MEM_CHECKSUM_EN.
module prog_mem #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  prog_mem_if.slave   bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_asm;
  logic [DATA_W-1:0] r_rd_data;
  logic [DATA_W-1:0] w_asm_word, w_flush_word, w_wr_data;
  logic [CNT_W-1:0]  r_byte_cnt;
  logic [ADDR_W:0]   r_words;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              r_overflow, r_rd_valid;
  logic              w_full, w_last, w_restart, w_accept, w_drop, w_wr_en, w_rd_ok;

  // words_loaded doubles as the write pointer; its MSB marks a full memory
  assign w_full    = r_words[ADDR_W];
  assign w_wr_addr = r_words[ADDR_W-1:0];
  assign w_last    = (r_byte_cnt == CNT_W'(BYTES - 1));
  assign w_rd_ok   = bus.rd_en && (r_state == IDLE);

  always_comb begin
    w_asm_word = r_asm;
    w_asm_word[{r_byte_cnt, 3'b000} +: 8] = bus.byte_in;
    w_flush_word = '0;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (CNT_W'(i) < r_byte_cnt) w_flush_word[8*i +: 8] = r_asm[8*i +: 8];
    end
  end

  always_comb begin
    w_next    = r_state;
    w_restart = 1'b0;
    w_accept  = 1'b0;
    w_drop    = 1'b0;
    w_wr_en   = 1'b0;
    w_wr_data = w_asm_word;
    case (r_state)
      IDLE: begin
        if (bus.load_start) begin
          w_restart = 1'b1;
          w_next    = LOAD;
        end
      end
      LOAD: begin
        if (bus.load_start) begin
          w_restart = 1'b1;
        end else begin
          if (bus.byte_valid) begin
            if (w_full) begin
              w_drop = 1'b1;
            end else begin
              w_accept = 1'b1;
              w_wr_en  = w_last;
            end
          end
          if (bus.load_done) w_next = FLUSH;
        end
      end
      FLUSH: begin
        w_next    = IDLE;
        w_wr_data = w_flush_word;
        w_wr_en   = (r_byte_cnt != '0) && !w_full;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_asm      <= '0;
      r_byte_cnt <= '0;
      r_words    <= '0;
      r_overflow <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= w_rd_ok;
      if (w_rd_ok) r_rd_data <= r_mem[bus.rd_addr];
      if (w_restart) begin
        r_byte_cnt <= '0;
        r_words    <= '0;
        r_overflow <= 1'b0;
      end else begin
        if (w_accept) begin
          r_asm      <= w_asm_word;
          r_byte_cnt <= w_last ? '0 : r_byte_cnt + 1'b1;
        end
        if (r_state == FLUSH) r_byte_cnt <= '0;
        if (w_drop) r_overflow <= 1'b1;
        if (w_wr_en) r_words <= r_words + 1'b1;
      end
    end
  end

  // Storage has no reset so a program survives rst
  always_ff @(posedge clk) begin
    if (w_wr_en && !rst) r_mem[w_wr_addr] <= w_wr_data;
  end

`ifdef PROG_MEM_CHECKSUM_EN
  logic [31:0] r_checksum;
  logic [31:0] w_cs_add;

  if (DATA_W >= 32) begin : g_cs_trunc
    assign w_cs_add = w_wr_data[31:0];
  end else begin : g_cs_ext
    assign w_cs_add = {{(32 - DATA_W){1'b0}}, w_wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst || w_restart) r_checksum <= '0;
    else if (w_wr_en)     r_checksum <= r_checksum + w_cs_add;
  end

  assign bus.checksum = r_checksum;
`else
  assign bus.checksum = '0;
`endif

  assign bus.loading      = (r_state != IDLE);
  assign bus.words_loaded = r_words;
  assign bus.overflow     = r_overflow;
  assign bus.rd_data      = r_rd_data;
  assign bus.rd_valid     = r_rd_valid;
endmodule

// File: tb/tb_prog_mem.sv
// Randomized scoreboard bench for prog_mem (ADDR_W=2 so memory-full behaviour is reachable).
module tb_prog_mem;
  localparam int AW    = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int BYTES = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prog_mem_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  prog_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  rd_exp_t     rq[$];
  logic [31:0] mem_m [DEPTH];
  bit          written [DEPTH];
  int          exp_words;
  bit          exp_ovf;
  logic [31:0] exp_cs;
  logic [31:0] last_rd;
  bit          mon_exp_v;
  rd_exp_t     mon_e;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [31:0] cs_exp();
`ifdef PROG_MEM_CHECKSUM_EN
    return exp_cs;
`else
    return 32'd0;
`endif
  endfunction

  // Read-side monitor: every returned word must match the queued expectation in the expected cycle
  always @(negedge clk) begin
    if (rst) begin
      rq.delete();
      last_rd = '0;
    end else begin
      mon_exp_v = (rq.size() > 0) && (rq[0].cyc == cycle);
      chk("rd_valid", 32'(bus.rd_valid), 32'(mon_exp_v));
      if (mon_exp_v) begin
        mon_e = rq.pop_front();
        chk("rd_data", bus.rd_data, mon_e.data);
        last_rd = mon_e.data;
      end else begin
        chk("rd_data_hold", bus.rd_data, last_rd);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_in    = '0;
    bus.load_done  = 1'b0;
    bus.rd_en      = 1'b0;
    bus.rd_addr    = '0;
  endtask

  // Session result from the byte list alone: grouped into little-endian words, capped at DEPTH
  task automatic apply_model(input logic [7:0] b[$], input bit flushed);
    int n;
    int nw;
    logic [31:0] word;
    n  = b.size();
    nw = flushed ? (n + BYTES - 1) / BYTES : n / BYTES;
    if (nw > DEPTH) nw = DEPTH;
    exp_cs = '0;
    for (int w = 0; w < nw; w++) begin
      word = '0;
      for (int j = 0; j < BYTES; j++)
        if (w * BYTES + j < n) word = word | (32'(b[w * BYTES + j]) << (8 * j));
      mem_m[w]   = word;
      written[w] = 1'b1;
      exp_cs     = exp_cs + word;
    end
    exp_words = nw;
    exp_ovf   = (n > DEPTH * BYTES);
  endtask

  task automatic status_check(input string tag);
    chk({tag, "_loading"}, 32'(bus.loading), 32'd0);
    chk({tag, "_words"}, 32'(bus.words_loaded), 32'(exp_words));
    chk({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    chk({tag, "_cs"}, bus.checksum, cs_exp());
  endtask

  // mode 0: close with load_done; 1: leave open (next session restarts it); 2: abort with rst
  task automatic run_session(input logic [7:0] b[$], input bit combine, input int mode);
    bit done_sent;
    done_sent = 1'b0;
    bus.load_start = 1'b1;
    cyc();
    bus.load_start = 1'b0;
    chk("start_loading", 32'(bus.loading), 32'd1);
    chk("start_words", 32'(bus.words_loaded), 32'd0);
    chk("start_ovf", 32'(bus.overflow), 32'd0);
    chk("start_cs", bus.checksum, 32'd0);
    foreach (b[i]) begin
      repeat ($urandom_range(0, 2)) begin
        bus.rd_en   = 1'($urandom_range(0, 1));
        bus.rd_addr = AW'($urandom);
        cyc();
        bus.rd_en = 1'b0;
      end
      bus.byte_valid = 1'b1;
      bus.byte_in    = b[i];
      if (mode == 0 && combine && i == b.size() - 1) begin
        bus.load_done = 1'b1;
        done_sent     = 1'b1;
      end
      cyc();
      bus.byte_valid = 1'b0;
      bus.load_done  = 1'b0;
    end
    if (mode == 0) begin
      if (!done_sent) begin
        bus.load_done = 1'b1;
        cyc();
        bus.load_done = 1'b0;
      end
      chk("flush_loading", 32'(bus.loading), 32'd1);
      bus.byte_valid = 1'($urandom_range(0, 1));
      bus.byte_in    = 8'($urandom);
      bus.load_start = ($urandom_range(0, 3) == 0);
      bus.rd_en      = 1'($urandom_range(0, 1));
      bus.rd_addr    = AW'($urandom);
      cyc();
      clear_inputs();
      apply_model(b, 1'b1);
      status_check("end");
    end else if (mode == 1) begin
      apply_model(b, 1'b0);
    end else begin
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      apply_model(b, 1'b0);
      exp_words = 0;
      exp_ovf   = 1'b0;
      exp_cs    = '0;
      status_check("rst_abort");
    end
  endtask

  task automatic read_addr(input logic [AW-1:0] a, input logic [31:0] expv);
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    rq.push_back('{data: expv, cyc: cycle + 1});
    cyc();
    bus.rd_en = 1'b0;
  endtask

  task automatic read_some(input int k);
    logic [AW-1:0] a;
    repeat (k) begin
      a = '0;
      for (int t = 0; t < 16; t++) begin
        a = AW'($urandom_range(0, DEPTH - 1));
        if (written[a]) break;
      end
      if (!written[a]) a = '0;
      bus.byte_valid = 1'($urandom_range(0, 1));
      bus.byte_in    = 8'($urandom);
      read_addr(a, mem_m[a]);
      bus.byte_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) cyc();
    end
    status_check("after_read");
  endtask

  initial begin
    logic [7:0]  bq[$];
    logic [63:0] v;
    int          mode;
    int          r;
    clear_inputs();
    for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;
    exp_words = 0;
    exp_ovf   = 1'b0;
    exp_cs    = '0;
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    chk("rst_loading", 32'(bus.loading), 32'd0);
    chk("rst_words", 32'(bus.words_loaded), 32'd0);
    chk("rst_ovf", 32'(bus.overflow), 32'd0);
    chk("rst_cs", bus.checksum, 32'd0);
    chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_rd_data", bus.rd_data, 32'd0);

    v = 64'h00100093_00000013;
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(v[8*i +: 8]);
    run_session(bq, 1'b0, 0);
    chk("two_words", 32'(bus.words_loaded), 32'd2);
    read_addr(2'd0, 32'h00000013);
    read_addr(2'd1, 32'h00100093);

    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'hAA + 8'(i));
    run_session(bq, 1'b0, 0);
    chk("partial_words", 32'(bus.words_loaded), 32'd2);
    read_addr(2'd1, 32'h0000AFAE);

    v = 64'h00000002_FFFFFFFF;
    bq.delete();
    for (int i = 0; i < 8; i++) bq.push_back(v[8*i +: 8]);
    run_session(bq, 1'b1, 0);
`ifdef PROG_MEM_CHECKSUM_EN
    chk("cs_wrap", bus.checksum, 32'h00000001);
`else
    chk("cs_off", bus.checksum, 32'h00000000);
`endif

    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(8'(i + 1));
    run_session(bq, 1'b0, 0);
    chk("full_words", 32'(bus.words_loaded), 32'd4);
    chk("full_ovf", 32'(bus.overflow), 32'd1);
    read_addr(2'd0, 32'h04030201);
    read_addr(2'd3, 32'h100F0E0D);

    bq.delete();
    for (int i = 0; i < 16; i++) bq.push_back(8'($urandom));
    run_session(bq, 1'b0, 0);
    read_some(4);

    bq.delete();
    bq.push_back(8'h5A);
    bq.push_back(8'hA5);
    run_session(bq, 1'b0, 2);
    for (int i = 0; i < DEPTH; i++) read_addr(AW'(i), mem_m[i]);

    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
    run_session(bq, 1'b0, 1);

    for (int s = 0; s < 40; s++) begin
      bq.delete();
      repeat ($urandom_range(0, 20)) bq.push_back(8'($urandom));
      r    = int'($urandom_range(0, 9));
      mode = (s == 39 || r > 1) ? 0 : (r == 0 ? 1 : 2);
      run_session(bq, 1'($urandom_range(0, 1)), mode);
      if (mode != 1) read_some(int'($urandom_range(1, 4)));
    end

    repeat (3) cyc();
    chk("rd_queue_drained", 32'(rq.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prog_mem.md
PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 Parameter ADDR_W, default 8, word address width; depth = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 32, word width in bits; SHALL be a multiple of 8; BYTES = DATA_W/8.
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 load_start  in  1  one-cycle pulse; opens a load session at word 0.
REQ-006 byte_valid  in  1  byte_in qualifier from the UART receiver.
REQ-007 byte_in  in  8  program byte, little-endian within a word.
REQ-008 load_done  in  1  one-cycle pulse; closes the load session.
REQ-009 loading  out  1  high while a load session is open, including flush.
REQ-010 words_loaded  out  ADDR_W+1  words written in the current or last session.
REQ-011 overflow  out  1  sticky; bytes were dropped because memory was full.
REQ-012 rd_en  in  1  CPU read request.
REQ-013 rd_addr  in  ADDR_W  CPU word address.
REQ-014 rd_data  out  DATA_W  registered read data.
REQ-015 rd_valid  out  1  rd_data updated this cycle.
REQ-016 checksum  out  32  running sum of words written (see Configuration).

Function
REQ-017 FSM states: IDLE, LOAD, FLUSH; reset state IDLE.
REQ-018 IDLE->LOAD on load_start; wr_ptr, byte count, words_loaded, overflow, checksum cleared in the same edge.
REQ-019 In LOAD, each byte_valid stores byte_in into byte lane k (bits 8k+7:8k) of the assembly register, k = byte count, then increments k.
REQ-020 When lane BYTES-1 is filled, the assembled word SHALL be written at wr_ptr on that same edge; wr_ptr and words_loaded increment; k returns to 0.
REQ-021 LOAD->FLUSH on load_done; FLUSH writes a partial word (k>0), unfilled lanes zero, then goes to IDLE; with k=0 FLUSH writes nothing; FLUSH lasts exactly one cycle.
REQ-022 byte_valid and load_done in the same cycle: byte is accepted first, then flush proceeds.
REQ-023 load_start while in LOAD restarts the session (as REQ-018); load_start in FLUSH is ignored.
REQ-024 When words_loaded = 2**ADDR_W, further bytes are dropped, no write occurs, overflow sets and holds until the next load_start or rst; wr_ptr never wraps.
REQ-025 byte_valid in IDLE or FLUSH is ignored.
REQ-026 Read latency 1: rd_en at cycle n gives rd_data = mem[rd_addr] and rd_valid=1 at cycle n+1.
REQ-027 While loading=1, rd_en is ignored: rd_valid=0, rd_data holds.
REQ-028 rd_valid is 0 in any cycle not following an accepted rd_en.
REQ-029 loading = 1 in LOAD and FLUSH, 0 in IDLE.

Reset
REQ-030 rst forces IDLE; loading, rd_valid, overflow, words_loaded, checksum, rd_data = 0.
REQ-031 Memory contents are not cleared by rst; rst mid-session aborts it, any partial word is discarded.

Configuration
REQ-032 Macro PROG_MEM_CHECKSUM_EN: defined -> checksum adds each written word (zero-extended or truncated to 32 bits) modulo 2**32, flush words included; undefined -> checksum constant 0, no adder synthesised.

Verification
REQ-033 load_start, bytes 0x13,0x00,0x00,0x00,0x93,0x00,0x10,0x00, load_done; rd addr 0,1 -> rd_data 0x00000013 then 0x00100093, words_loaded=2.
REQ-034 Session of 6 bytes 0xAA..0xAF, load_done -> word1 = 0x0000AFAE, words_loaded=2, loading low 1 cycle after FLUSH.
REQ-035 ADDR_W=2: load 20 bytes -> words_loaded=4, overflow=1, mem[0] unchanged from first word; new load_start clears overflow.
REQ-036 rd_en during LOAD -> rd_valid stays 0; rd_en in IDLE at cycle n -> rd_valid=1 at n+1 only.
REQ-037 rst asserted after 2 bytes -> IDLE, loading=0, words_loaded=0; previously stored words still readable.
REQ-038 With PROG_MEM_CHECKSUM_EN, words 0xFFFFFFFF and 0x00000002 -> checksum=0x00000001; without macro -> 0.
